// File: rtl/rc_sensor_pkg.sv
// Shared types and defaults for the RC-decay reflectance sensor reader.
package rc_sensor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHARGE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DEF_NUM_CH         = 8;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_CHARGE_CYCLES  = 500;
  localparam int DEF_TIMEOUT_CYCLES = 20000;
  localparam int DEF_SYNC_STAGES    = 2;

  // Lowest bit of channel ch inside a flattened array of width-bit fields.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/rc_channel_capture.sv
// One sensor channel: synchronises the pad, then latches the first timer value
// seen while the node reads low, or the saturation value on timeout.
module rc_channel_capture
  import rc_sensor_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sense,
  input  logic             i_arm,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_timer,
  input  logic             i_timeout,
  output logic             o_captured,
  output logic [CNT_W-1:0] o_value
);

  localparam logic [CNT_W-1:0] SAT_VALUE = CNT_W'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_captured;
  logic [CNT_W-1:0]       r_value;
  logic                   w_sense_low;

  assign w_sense_low = ~r_sync[SYNC_STAGES-1];

  // Shift the asynchronous pad level through the synchroniser chain.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sense};
  end

  // First low wins; a timeout only fills channels that never went low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_captured <= 1'b0;
      r_value    <= '0;
    end else if (i_clear) begin
      r_captured <= 1'b0;
    end else if (i_arm && !r_captured) begin
      if (w_sense_low) begin
        r_value    <= i_timer;
        r_captured <= 1'b1;
      end else if (i_timeout) begin
        r_value    <= SAT_VALUE;
      end
    end
  end

  assign o_captured = r_captured;
  assign o_value    = r_value;

endmodule

// File: rtl/rc_sensor_array_reader.sv
// Reader for an array of RC-decay reflectance sensors: charge, release,
// time the decay per channel, publish decay times and line-detect bits.
module rc_sensor_array_reader
  import rc_sensor_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int CHARGE_CYCLES  = DEF_CHARGE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_continuous,
  input  logic [CNT_W-1:0]        i_threshold,
  input  logic [NUM_CH-1:0]       i_sense_in,
  output logic [NUM_CH-1:0]       o_drive_oe,
  output logic [NUM_CH-1:0]       o_drive_out,
  output logic                    o_busy,
  output logic                    o_sample_valid,
  output logic [NUM_CH*CNT_W-1:0] o_decay_time,
  output logic [NUM_CH-1:0]       o_line_detect
);

  localparam logic [CNT_W-1:0] CHARGE_LAST  = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_timer;
  logic [NUM_CH-1:0]       r_drive_oe;
  logic [NUM_CH-1:0]       r_drive_out;
  logic                    r_busy;
  logic                    r_sample_valid;
  logic [NUM_CH*CNT_W-1:0] r_decay_time;
  logic [NUM_CH-1:0]       r_line_detect;

  logic                    w_arm;
  logic                    w_clear;
  logic                    w_timeout;
  logic                    w_all_captured;
  logic [NUM_CH-1:0]       w_captured;
  logic [NUM_CH-1:0]       w_line_detect;
  logic [NUM_CH*CNT_W-1:0] w_value;

  assign w_arm          = (r_state == ST_MEASURE);
  assign w_clear        = (r_state == ST_DONE);
  assign w_timeout      = w_arm && (r_timer == TIMEOUT_LAST);
  assign w_all_captured = &w_captured;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    rc_channel_capture #(
      .CNT_W          (CNT_W),
      .SYNC_STAGES    (SYNC_STAGES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_capture (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_sense    (i_sense_in[gi]),
      .i_arm      (w_arm),
      .i_clear    (w_clear),
      .i_timer    (r_timer),
      .i_timeout  (w_timeout),
      .o_captured (w_captured[gi]),
      .o_value    (w_value[ch_lsb(gi, CNT_W) +: CNT_W])
    );

    // Unsigned compare against the threshold presented during DONE.
    assign w_line_detect[gi] = (w_value[ch_lsb(gi, CNT_W) +: CNT_W] >= i_threshold);
  end

  // Sequencer: charge, measure, publish; pad controls and flags registered with the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_drive_oe     <= '0;
      r_drive_out    <= '0;
      r_busy         <= 1'b0;
      r_sample_valid <= 1'b0;
      r_decay_time   <= '0;
      r_line_detect  <= '0;
    end else begin
      r_sample_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start || i_continuous) begin
            r_state     <= ST_CHARGE;
            r_timer     <= '0;
            r_drive_oe  <= '1;
            r_drive_out <= '1;
            r_busy      <= 1'b1;
          end
        end
        ST_CHARGE: begin
          if (r_timer == CHARGE_LAST) begin
            r_state     <= ST_MEASURE;
            r_timer     <= '0;
            r_drive_oe  <= '0;
            r_drive_out <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_all_captured || w_timeout) begin
            r_state <= ST_DONE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DONE: begin
          r_decay_time   <= w_value;
          r_line_detect  <= w_line_detect;
          r_sample_valid <= 1'b1;
          if (i_continuous) begin
            r_state     <= ST_CHARGE;
            r_drive_oe  <= '1;
            r_drive_out <= '1;
            r_busy      <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_timer     <= '0;
          r_drive_oe  <= '0;
          r_drive_out <= '0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_drive_oe     = r_drive_oe;
  assign o_drive_out    = r_drive_out;
  assign o_busy         = r_busy;
  assign o_sample_valid = r_sample_valid;
  assign o_decay_time   = r_decay_time;
  assign o_line_detect  = r_line_detect;

endmodule

// File: tb/tb_rc_sensor_array_reader.sv
// Bench for rc_sensor_array_reader: a timeline model of each sample predicts
// every output on every cycle; directed tests add hand-computed literals.
module tb_rc_sensor_array_reader;

  localparam int NCH = 8;
  localparam int CW  = 16;
  localparam int CH  = 500;
  localparam int TO  = 20000;
  localparam int SS  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              cont;
  logic [CW-1:0]     thr;
  logic [NCH-1:0]    sense;
  logic [NCH-1:0]    drive_oe;
  logic [NCH-1:0]    drive_out;
  logic              busy;
  logic              valid;
  logic [NCH*CW-1:0] decay;
  logic [NCH-1:0]    line;

  always #5 clk = ~clk;

  rc_sensor_array_reader #(
    .NUM_CH(NCH), .CNT_W(CW), .CHARGE_CYCLES(CH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_continuous(cont),
    .i_threshold(thr), .i_sense_in(sense),
    .o_drive_oe(drive_oe), .o_drive_out(drive_out), .o_busy(busy),
    .o_sample_valid(valid), .o_decay_time(decay), .o_line_detect(line)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_cnt = 0;

  // Pad behaviour per channel, in MEASURE-cycle units: low from fall_k up to
  // (not including) rise_k; -1 means never falls / never rises again.
  int fall_k[NCH];
  int rise_k[NCH];

  // Model: trigger cycle of the current sample (-1 idle), its measure length
  // and predicted per-channel decay values.
  int                m_t0 = -1;
  int                m_len = 0;
  int                m_dec[NCH];
  logic [NCH*CW-1:0] exp_decay = '0;
  logic [NCH-1:0]    exp_ld = '0;
  logic              exp_valid = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Decay = first low cycle + synchroniser delay, or TIMEOUT if that never
  // lands inside the window; the window closes 2 cycles after the last capture.
  task automatic plan();
    int mx;
    mx = 0;
    for (int i = 0; i < NCH; i++) begin
      if (fall_k[i] >= 0 && fall_k[i] + SS <= TO - 1) m_dec[i] = fall_k[i] + SS;
      else                                            m_dec[i] = TO;
      if (m_dec[i] > mx) mx = m_dec[i];
    end
    m_len = (mx + 2 < TO) ? mx + 2 : TO;
  endtask

  // Model update at each edge from the inputs the DUT sampled, then pad drive.
  initial begin
    int off, k;
    sense = '1;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_t0 = -1; exp_valid = 1'b0; exp_decay = '0; exp_ld = '0;
      end else begin
        exp_valid = 1'b0;
        if (m_t0 >= 0 && cyc - m_t0 == CH + m_len + 1) begin
          for (int i = 0; i < NCH; i++) begin
            exp_decay[i*CW +: CW] = CW'(m_dec[i]);
            exp_ld[i] = (m_dec[i] >= int'(thr));
          end
          exp_valid = 1'b1;
          if (cont) begin m_t0 = cyc; plan(); end
          else m_t0 = -1;
        end else if (m_t0 < 0 && (start || cont)) begin
          m_t0 = cyc;
          plan();
        end
      end
      cyc++;
      #1;
      sense = '1;
      if (m_t0 >= 0) begin
        off = cyc - m_t0;
        k = off - (CH + 1);
        if (k >= 0 && off <= CH + m_len + 1)
          for (int i = 0; i < NCH; i++)
            if (fall_k[i] >= 0 && k >= fall_k[i] && (rise_k[i] < 0 || k < rise_k[i]))
              sense[i] = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    int off;
    logic m_busy, m_chg;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        off    = cyc - m_t0;
        m_busy = (m_t0 >= 0) && off >= 1 && off <= CH + m_len + 1;
        m_chg  = (m_t0 >= 0) && off >= 1 && off <= CH;
        check("busy", busy, m_busy);
        check("drive_oe", drive_oe, m_chg ? {NCH{1'b1}} : {NCH{1'b0}});
        check("drive_out", drive_out, m_chg ? {NCH{1'b1}} : {NCH{1'b0}});
        check("sample_valid", valid, exp_valid);
        check("decay_time", decay, exp_decay);
        check("line_detect", line, exp_ld);
        if (valid) begin
          valid_cnt++;
          $display("sample %0d cycle %0d: decay=%h line_detect=%b", valid_cnt, cyc, decay, line);
        end
      end
    end
  end

  task automatic set_pads(input int base, input int step, input int odd_ch, input int odd_fall);
    for (int i = 0; i < NCH; i++) begin
      fall_k[i] = base + step * i;
      rise_k[i] = -1;
    end
    if (odd_ch >= 0) fall_k[odd_ch] = odd_fall;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_ch(input string name, input int ch, input int req);
    logic [CW-1:0] f;
    f = decay[ch*CW +: CW];
    check(name, f, req);
  endtask

  initial begin
    int v0;
    rst = 1'b1; start = 1'b0; cont = 1'b0; thr = '0;
    set_pads(-1, 0, -1, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    repeat (100) @(posedge clk);
    #1;
    check("t1_busy", busy, 0);
    check("t1_oe", drive_oe, 0);
    check("t1_decay", decay, 0);
    check("t1_valid_cnt", valid_cnt, 0);

    // Staggered falls, early exit after channel 7
    set_pads(100, 100, -1, 0);
    thr = 16'd500;
    v0 = valid_cnt;
    pulse_start();
    repeat (CH + 820) @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) check_ch("t2_decay", i, 100 * (i + 1) + 2);
    check("t2_line", line, 8'b1111_0000);
    check("t2_valids", valid_cnt - v0, 1);
    check("t2_busy", busy, 0);

    // Channel 3 never falls: saturates at TIMEOUT
    set_pads(50, 0, 3, -1);
    thr = 16'd1000;
    v0 = valid_cnt;
    pulse_start();
    repeat (CH + TO + 10) @(posedge clk);
    #1;
    check_ch("t3_decay3", 3, 20000);
    check_ch("t3_decay0", 0, 52);
    check_ch("t3_decay7", 7, 52);
    check("t3_line", line, 8'b0000_1000);
    check("t3_valids", valid_cnt - v0, 1);

    // Continuous for three samples (decays 22..162, window 164 cycles)
    set_pads(20, 20, -1, 0);
    thr = 16'd100;
    v0 = valid_cnt;
    cont = 1'b1;
    repeat (2 * (CH + 165) + CH + 1 + 50) @(posedge clk);
    #1 cont = 1'b0;
    repeat (CH + 200) @(posedge clk);
    #1;
    check("t4_valids", valid_cnt - v0, 3);
    check("t4_busy", busy, 0);
    check_ch("t4_decay4", 4, 102);
    check("t4_line", line, 8'b1111_0000);

    // Reset at MEASURE cycle 300, then a clean sample
    set_pads(400, 0, -1, 0);
    v0 = valid_cnt;
    pulse_start();
    repeat (CH + 300) @(posedge clk);
    #1;
    check("t5_busy_pre", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_oe", drive_oe, 0);
    check("t5_decay", decay, 0);
    check("t5_line", line, 0);
    check("t5_busy", busy, 0);
    repeat (CH + 420) @(posedge clk);
    #1;
    check("t5_valids_none", valid_cnt - v0, 0);
    pulse_start();
    repeat (CH + 420) @(posedge clk);
    #1;
    check_ch("t5_decay_after", 5, 402);
    check("t5_valids", valid_cnt - v0, 1);

    // Start during CHARGE ignored; channel 0 glitches low for one cycle at 10
    set_pads(50, 0, -1, 0);
    fall_k[0] = 10;
    rise_k[0] = 11;
    v0 = valid_cnt;
    pulse_start();
    repeat (100) @(posedge clk);
    #1;
    pulse_start();
    repeat (CH + 100) @(posedge clk);
    #1;
    check_ch("t6_decay0", 0, 12);
    check_ch("t6_decay1", 1, 52);
    check("t6_valids", valid_cnt - v0, 1);
    check("t6_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
